ad9911_spi_writer: RTL and testbench

AD9911_SPI_WRITER -- requirements
Module: ad9911_spi_writer

---
 rtl/ad9911_pkg.sv | 59 +++++
 rtl/ad9911_sclk_div.sv | 40 ++++
 rtl/ad9911_spi_writer.sv | 140 ++++++++++++++
 tb/tb_ad9911_spi_writer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9911_pkg.sv
// Shared definitions for the AD9911 register writer: register map,
// FSM encoding and the address-to-register-width decode.
package ad9911_pkg;

    // AD9911 register addresses
    localparam logic [7:0] CSR   = 8'h00;
    localparam logic [7:0] FR1   = 8'h01;
    localparam logic [7:0] FR2   = 8'h02;
    localparam logic [7:0] CFR   = 8'h03;
    localparam logic [7:0] CTW0  = 8'h04;
    localparam logic [7:0] CPOW0 = 8'h05;
    localparam logic [7:0] ACR   = 8'h06;
    localparam logic [7:0] LSRR  = 8'h07;
    localparam logic [7:0] RDW   = 8'h08;
    localparam logic [7:0] FDW   = 8'h09;
    localparam logic [7:0] CTW1  = 8'h0A;
    localparam logic [7:0] CTW15 = 8'h18;

    // Longest frame: 8-bit instruction plus 32-bit register
    localparam int FRAME_W = 40;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_IOUP  = 3'd3,
        ST_ERR   = 3'd4
    } ad9911_state_t;

    // Register width in bits for an address; 0 marks an invalid address.
    function automatic logic [5:0] addr_width(input logic [7:0] addr);
        logic [5:0] w;
        w = 6'd0;
        case (addr)
            CSR:               w = 6'd8;
            FR1, CFR, ACR:     w = 6'd24;
            FR2, CPOW0, LSRR:  w = 6'd16;
            CTW0:              w = 6'd32;
            default: begin
                if (addr >= RDW && addr <= CTW15) w = 6'd32;
                else                              w = 6'd0;
            end
        endcase
        return w;
    endfunction

    // Full frame left-justified: write instruction byte on top, then the
    // low 'width' bits of data, MSB first; unused low bits are zero.
    function automatic logic [FRAME_W-1:0] frame_word(input logic [7:0]  addr,
                                                      input logic [31:0] data,
                                                      input logic [5:0]  width);
        logic [7:0]  instr;
        logic [31:0] body;
        instr = {1'b0, 2'b00, addr[4:0]};
        body  = data << (6'd32 - width);
        return {instr, body};
    endfunction

endpackage

// File: rtl/ad9911_sclk_div.sv
// SCLK phase timing: counts CLK_DIV cycles per half-period while enabled
// and flags the last cycle of the low and high phases.
module ad9911_sclk_div
    import ad9911_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;
    logic       phase;

    // Half-period counter; parked at the start of a low phase when disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 8'd0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= 8'd0;
            phase <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= 8'd0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    // rise: last low cycle (SCLK goes high next); fall: last high cycle (bit ends)
    assign rise = en && (cnt == LAST) && !phase;
    assign fall = en && (cnt == LAST) &&  phase;

endmodule

// File: rtl/ad9911_spi_writer.sv
// AD9911 serial register writer: one TR rising edge writes ADDR/DATA as a
// write-instruction frame, then strobes IO_UPDATE.
//
// Handshake: the master raises TR with ADDR/DATA valid; a registered rising
// edge seen while idle is accepted and BUSY rises the next cycle (the
// "ready/ack"). ADDR/DATA are captured on acceptance, so the master may
// drop TR and change inputs once BUSY is seen. BUSY low means a new edge can
// be accepted; a level held on TR never starts a second transfer.
module ad9911_spi_writer
    import ad9911_pkg::*;
#(
    parameter int CLK_DIV     = 1,
    parameter int IOUP_CYCLES = 4
) (
    input  logic          CLOCK_10M,
    input  logic          RESET_N,
    input  logic          TR,
    input  logic [7:0]    ADDR,
    input  logic [31:0]   DATA,
    output logic          BUSY,
    output logic          ADDR_ERR,
    output logic          CS_N,
    output logic          SCLK,
    output logic          SDIO,
    output logic          IO_UPDATE,
    output ad9911_state_t fsm_state
);

    localparam logic [7:0] IOUP_LAST = 8'(IOUP_CYCLES - 1);

    ad9911_state_t      state;
    logic               tr_q;
    logic [FRAME_W-2:0] sreg;
    logic [5:0]         bits_left;
    logic [7:0]         ioup_cnt;
    logic [5:0]         width;
    logic [FRAME_W-1:0] frame;
    logic               tr_rise;
    logic               sclk_rise;
    logic               bit_end;

    assign width     = addr_width(ADDR);
    assign frame     = frame_word(ADDR, DATA, width);
    assign tr_rise   = TR && !tr_q;
    assign fsm_state = state;

    ad9911_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk   (CLOCK_10M),
        .rst_n (RESET_N),
        .en    (state == ST_SHIFT),
        .rise  (sclk_rise),
        .fall  (bit_end)
    );

    // Transfer FSM with all interface outputs registered
    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            tr_q      <= 1'b0;
            sreg      <= '0;
            bits_left <= 6'd0;
            ioup_cnt  <= 8'd0;
            BUSY      <= 1'b0;
            ADDR_ERR  <= 1'b0;
            CS_N      <= 1'b1;
            SCLK      <= 1'b0;
            SDIO      <= 1'b0;
            IO_UPDATE <= 1'b0;
        end else begin
            tr_q <= TR;
            case (state)
                ST_IDLE: begin
                    if (tr_rise) begin
                        BUSY <= 1'b1;
                        if (width == 6'd0) begin
                            state    <= ST_ERR;
                            ADDR_ERR <= 1'b1;
                        end else begin
                            state     <= ST_LOAD;
                            CS_N      <= 1'b0;
                            SCLK      <= 1'b0;
                            SDIO      <= frame[FRAME_W-1];
                            sreg      <= frame[FRAME_W-2:0];
                            bits_left <= width + 6'd7;
                        end
                    end
                end
                ST_ERR: begin
                    state    <= ST_IDLE;
                    BUSY     <= 1'b0;
                    ADDR_ERR <= 1'b0;
                end
                ST_LOAD: begin
                    // First bit is already on SDIO; its low phase starts in SHIFT
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        SCLK <= 1'b1;
                    end else if (bit_end) begin
                        SCLK <= 1'b0;
                        if (bits_left == 6'd0) begin
                            state     <= ST_IOUP;
                            CS_N      <= 1'b1;
                            SDIO      <= 1'b0;
                            IO_UPDATE <= 1'b1;
                            ioup_cnt  <= IOUP_LAST;
                        end else begin
                            // Next bit changes together with the SCLK fall
                            SDIO      <= sreg[FRAME_W-2];
                            sreg      <= {sreg[FRAME_W-3:0], 1'b0};
                            bits_left <= bits_left - 6'd1;
                        end
                    end
                end
                ST_IOUP: begin
                    if (ioup_cnt == 8'd0) begin
                        state     <= ST_IDLE;
                        IO_UPDATE <= 1'b0;
                        BUSY      <= 1'b0;
                    end else begin
                        ioup_cnt <= ioup_cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    BUSY      <= 1'b0;
                    ADDR_ERR  <= 1'b0;
                    CS_N      <= 1'b1;
                    SCLK      <= 1'b0;
                    SDIO      <= 1'b0;
                    IO_UPDATE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad9911_spi_writer.sv
// Bench for ad9911_spi_writer: cycle-level reference model of the frame
// timing plus directed transfers with hand-computed frame checks.
module tb_ad9911_spi_writer;
    import ad9911_pkg::*;

    localparam int D    = 1;
    localparam int IOUP = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tr = 1'b0;
    logic [7:0]    addr = 8'h00;
    logic [31:0]   data = 32'h0;
    logic          busy, addr_err, cs_n, sclk, sdio, io_update;
    ad9911_state_t fsm_state;

    always #50 clk = ~clk;

    ad9911_spi_writer #(
        .CLK_DIV     (D),
        .IOUP_CYCLES (IOUP)
    ) dut (
        .CLOCK_10M (clk),
        .RESET_N   (rst_n),
        .TR        (tr),
        .ADDR      (addr),
        .DATA      (data),
        .BUSY      (busy),
        .ADDR_ERR  (addr_err),
        .CS_N      (cs_n),
        .SCLK      (sclk),
        .SDIO      (sdio),
        .IO_UPDATE (io_update),
        .fsm_state (fsm_state)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // Register width straight from the AD9911 register map table
    function automatic int ref_width(input logic [7:0] a);
        if (a == 8'h00) return 8;
        if (a == 8'h01 || a == 8'h03 || a == 8'h06) return 24;
        if (a == 8'h02 || a == 8'h05 || a == 8'h07) return 16;
        if (a == 8'h04) return 32;
        if (a >= 8'h08 && a <= 8'h18) return 32;
        return 0;
    endfunction

    bit          m_active = 1'b0;
    bit          m_tr_q   = 1'b0;
    int          m_t, m_n, m_bits, m_len;
    logic [63:0] m_frame;

    // Model advances one cycle per clock: a transfer is just an offset
    // m_t into a frame of known length.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_tr_q   = 1'b0;
        end else begin
            if (m_active) begin
                m_t = m_t + 1;
                if (m_t >= m_len) m_active = 1'b0;
            end else if (tr && !m_tr_q) begin
                m_n      = ref_width(addr);
                m_bits   = 8 + m_n;
                m_t      = 0;
                m_active = 1'b1;
                if (m_n == 0) begin
                    m_len = 1;
                end else begin
                    m_len   = 1 + 2 * D * m_bits + IOUP;
                    m_frame = ({59'd0, addr[4:0]} << m_n) |
                              ({32'd0, data} & ((64'd1 << m_n) - 64'd1));
                end
            end
            m_tr_q = tr;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [6:0] exp_v, act_v;
        logic e_busy, e_err, e_cs, e_sclk, e_io, e_sdio, e_act;
        bit   chk_sdio;
        int   s;
        e_busy = 0; e_err = 0; e_cs = 1; e_sclk = 0; e_io = 0; e_sdio = 0;
        e_act = 0; chk_sdio = 1;
        if (rst_n && m_active) begin
            e_busy = 1;
            e_act  = 1;
            if (m_n == 0) begin
                e_err = 1;
            end else if (m_t == 0) begin
                e_cs   = 0;
                e_sdio = m_frame[m_bits-1];
            end else if (m_t <= 2 * D * m_bits) begin
                s      = m_t - 1;
                e_cs   = 0;
                e_sclk = ((s % (2 * D)) >= D);
                e_sdio = m_frame[m_bits - 1 - s / (2 * D)];
            end else begin
                e_io     = 1;
                chk_sdio = 0;
            end
        end
        exp_v = {e_act, e_busy, e_err, e_cs, e_sclk, e_io, e_sdio};
        act_v = {(fsm_state != ST_IDLE), busy, addr_err, cs_n, sclk, io_update,
                 chk_sdio ? sdio : 1'b0};
        total = total + 1;
        if (act_v !== exp_v) begin
            bad = bad + 1;
            $display("FAIL cycle_model t=%0t got {act,busy,err,cs_n,sclk,ioup,sdio}=%b want %b",
                     $time, act_v, exp_v);
        end
    end

    // ---------------- frame monitor (negedge sampled) ----------------
    int          rises, frames, io_pulses, io_cycles, err_cycles, busy_cycles;
    logic [63:0] cap;
    logic        sclk_p = 1'b0, cs_p = 1'b1, io_p = 1'b0;

    always @(negedge clk) begin
        if (sclk && !sclk_p) begin
            rises = rises + 1;
            cap   = {cap[62:0], sdio};
        end
        if (!cs_n && cs_p)        frames = frames + 1;
        if (io_update && !io_p)   io_pulses = io_pulses + 1;
        if (io_update)            io_cycles = io_cycles + 1;
        if (addr_err)             err_cycles = err_cycles + 1;
        if (busy)                 busy_cycles = busy_cycles + 1;
        sclk_p = sclk;
        cs_p   = cs_n;
        io_p   = io_update;
    end

    // ---------------- driver / check tasks ----------------
    task automatic clear_mon();
        rises = 0; frames = 0; io_pulses = 0; io_cycles = 0;
        err_cycles = 0; busy_cycles = 0; cap = 64'd0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int limit, input string name);
        int n;
        n = 0;
        while (busy !== lvl && n < limit) begin
            @(negedge clk);
            n = n + 1;
        end
        if (busy !== lvl) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL %s timeout got busy=%b want %b", name, busy, lvl);
        end
    endtask

    // Master handshake: raise TR, hold until BUSY, drop, wait for BUSY low
    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #2;
        addr = a; data = d; tr = 1'b1;
        @(negedge clk);
        wait_busy(1'b1, 10, "busy_rise");
        @(posedge clk); #2;
        tr = 1'b0;
        addr = ~a; data = ~d;
        @(negedge clk);
        wait_busy(1'b0, 300, "busy_fall");
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] wa;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_cs_n", {63'd0, cs_n}, 64'd1);
        check("reset_busy", {63'd0, busy}, 64'd0);

        // 32-bit CTW0 write
        clear_mon();
        do_write(8'h04, 32'h1614_2B21);
        check("ctw0_busy_len", busy_cycles, 85);
        check("ctw0_rises", rises, 40);
        check("ctw0_sdio", cap, 64'h04_1614_2B21);
        check("ctw0_io_pulses", io_pulses, 1);
        check("ctw0_io_width", io_cycles, 4);
        check("ctw0_frames", frames, 1);

        // 8-bit CSR write
        clear_mon();
        do_write(8'h00, 32'h0000_0020);
        check("csr_busy_len", busy_cycles, 37);
        check("csr_rises", rises, 16);
        check("csr_sdio", cap, 64'h0020);

        // Invalid address
        clear_mon();
        do_write(8'h1F, 32'hDEAD_BEEF);
        check("bad_addr_err", err_cycles, 1);
        check("bad_busy_len", busy_cycles, 1);
        check("bad_frames", frames, 0);
        check("bad_rises", rises, 0);
        check("bad_io", io_pulses, 0);

        // Back-to-back writes to 0x00..0x0A
        clear_mon();
        for (int i = 0; i <= 10; i++) begin
            wa = 8'(i);
            do_write(wa, 32'h9E37_79B9 ^ (32'(i) * 32'h0101_0101));
        end
        check("seq_frames", frames, 11);
        check("seq_rises", rises, 344);
        check("seq_io_pulses", io_pulses, 11);
        check("seq_err", err_cycles, 0);

        // TR held high for 200 cycles: one 16-bit CPOW0 frame only
        clear_mon();
        @(posedge clk); #2;
        addr = 8'h05; data = 32'h0000_BEEF; tr = 1'b1;
        repeat (200) @(posedge clk);
        #2 tr = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_frames", frames, 1);
        check("hold_busy_len", busy_cycles, 53);
        check("hold_sdio", cap, 64'h05_BEEF);

        // Reset mid-shift, then TR already high at release starts a frame
        clear_mon();
        @(posedge clk); #2;
        addr = 8'h04; data = 32'h1234_5678; tr = 1'b1;
        @(negedge clk);
        wait_busy(1'b1, 10, "abort_busy_rise");
        @(posedge clk); #2 tr = 1'b0;
        for (int n = 0; n < 200 && rises < 10; n++) @(negedge clk);
        check("abort_reached_bit10", rises, 10);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n", {63'd0, cs_n}, 64'd1);
        check("abort_busy", {63'd0, busy}, 64'd0);
        tr = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        check("abort_no_io", io_pulses, 0);
        clear_mon();
        @(negedge clk);
        wait_busy(1'b1, 10, "post_reset_rise");
        @(posedge clk); #2 tr = 1'b0;
        @(negedge clk);
        wait_busy(1'b0, 300, "post_reset_fall");
        repeat (3) @(negedge clk);
        check("post_reset_frames", frames, 1);
        check("post_reset_busy_len", busy_cycles, 85);
        check("post_reset_io", io_pulses, 1);
        check("post_reset_sdio", cap, 64'h04_1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want finish");
        bad = bad + 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
